// File: rtl/mem_crc_checker.sv
// mem_crc_checker: checks a memory word against its stored CRC.
// The CRC is computed bit-serially, MSB first, with an initial value of 0,
// no reflection and no final XOR.
//   clk, rst              clock and asynchronous active-high reset
//   chk_start             request a check of mem_data_in / crc_data_in
//   mem_data_in           data word read back from memory
//   crc_data_in           CRC value read back from memory
//   err_clr               clears crc_err and err_count
//   chk_busy              high while a check is in progress
//   chk_done              one-cycle pulse when a check completes
//   chk_pass              result of the last check (1 = match)
//   crc_err               sticky mismatch flag
//   err_count             saturating mismatch counter
module mem_crc_checker #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned POLYNOMIAL_BITS = 1,
  parameter int unsigned POLYNOMIAL      = 1,
  parameter int unsigned ERR_CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chk_start,
  input  logic [DATA_WIDTH-1:0]      mem_data_in,
  input  logic [POLYNOMIAL_BITS-1:0] crc_data_in,
  input  logic                       err_clr,
  output logic                       chk_busy,
  output logic                       chk_done,
  output logic                       chk_pass,
  output logic                       crc_err,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  localparam int unsigned W     = POLYNOMIAL_BITS;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [W-1:0]             POLY    = W'(POLYNOMIAL);
  localparam logic [IDX_W-1:0]         IDX_TOP = IDX_W'(DATA_WIDTH - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMPARE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] data_q;
  logic [W-1:0]          crc_q;
  logic [W-1:0]          lfsr;
  logic [W-1:0]          lfsr_nxt;
  logic [IDX_W-1:0]      idx;
  logic                  pass_q;
  logic                  fb;
  logic                  match;
  logic                  mismatch_evt;

  // For W=1 the shift drops the only bit, leaving just the feedback term.
  always_comb begin
    fb       = lfsr[W-1] ^ data_q[idx];
    lfsr_nxt = (lfsr << 1) ^ (fb ? POLY : '0);
  end

  assign match        = (lfsr == crc_q);
  assign mismatch_evt = (state == COMPARE) && !match;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (chk_start) state_nxt = CALC;
      CALC:    if (idx == '0) state_nxt = COMPARE;
      COMPARE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: chk_pass shows the live compare result during COMPARE so it is
  // valid alongside chk_done, and the registered copy afterwards.
  always_comb begin
    chk_busy = (state != IDLE);
    chk_done = (state == COMPARE);
    chk_pass = (state == COMPARE) ? match : pass_q;
  end

  // Datapath: shadow registers, LFSR, bit index, last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      crc_q  <= '0;
      lfsr   <= '0;
      idx    <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chk_start) begin
            data_q <= mem_data_in;
            crc_q  <= crc_data_in;
            lfsr   <= '0;
            idx    <= IDX_TOP;
          end
        end
        CALC: begin
          lfsr <= lfsr_nxt;
          if (idx != '0) idx <= idx - 1'b1;
        end
        COMPARE: pass_q <= match;
        default: ;
      endcase
    end
  end

  // Error tracking: a mismatch coinciding with err_clr counts as the first
  // event after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_err   <= 1'b0;
      err_count <= '0;
    end else if (mismatch_evt) begin
      crc_err <= 1'b1;
      if (err_clr)                err_count <= CNT_ONE;
      else if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
    end else if (err_clr) begin
      crc_err   <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_mem_crc_checker.sv
module tb_mem_crc_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (8-bit data, 1-bit parity CRC)
  logic       a_start = 1'b0;
  logic       a_clr   = 1'b0;
  logic [7:0] a_mem   = '0;
  logic       a_crc   = 1'b0;
  logic       a_busy, a_done, a_pass, a_err;
  logic [7:0] a_cnt;

  // Instance B: CRC-8, polynomial 0x07
  logic       b_start = 1'b0;
  logic       b_clr   = 1'b0;
  logic [7:0] b_mem   = '0;
  logic [7:0] b_crc   = '0;
  logic       b_busy, b_done, b_pass, b_err;
  logic [7:0] b_cnt;

  // Instance C: 2-bit saturating error counter
  logic       c_start = 1'b0;
  logic       c_clr   = 1'b0;
  logic [7:0] c_mem   = '0;
  logic       c_crc   = 1'b0;
  logic       c_busy, c_done, c_pass, c_err;
  logic [1:0] c_cnt;

  mem_crc_checker dut_a (
    .clk(clk), .rst(rst), .chk_start(a_start), .mem_data_in(a_mem),
    .crc_data_in(a_crc), .err_clr(a_clr), .chk_busy(a_busy), .chk_done(a_done),
    .chk_pass(a_pass), .crc_err(a_err), .err_count(a_cnt)
  );

  mem_crc_checker #(
    .DATA_WIDTH(8), .POLYNOMIAL_BITS(8), .POLYNOMIAL(32'h07), .ERR_CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst(rst), .chk_start(b_start), .mem_data_in(b_mem),
    .crc_data_in(b_crc), .err_clr(b_clr), .chk_busy(b_busy), .chk_done(b_done),
    .chk_pass(b_pass), .crc_err(b_err), .err_count(b_cnt)
  );

  mem_crc_checker #(
    .DATA_WIDTH(8), .POLYNOMIAL_BITS(1), .POLYNOMIAL(1), .ERR_CNT_WIDTH(2)
  ) dut_c (
    .clk(clk), .rst(rst), .chk_start(c_start), .mem_data_in(c_mem),
    .crc_data_in(c_crc), .err_clr(c_clr), .chk_busy(c_busy), .chk_done(c_done),
    .chk_pass(c_pass), .crc_err(c_err), .err_count(c_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a check on A; returns edges from start edge to chk_done, the
  // chk_pass/chk_busy seen with chk_done. Inputs are scrambled after capture.
  task automatic run_a(input logic [7:0] d, input logic c, input bit clr_cmp,
                       output int lat, output logic pass, output logic bsy);
    a_mem = d; a_crc = c; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_mem = ~d; a_crc = ~c;
    lat = 0;
    while (a_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (clr_cmp) a_clr = 1'b1;
    pass = a_pass;
    bsy  = a_busy;
    tick();
    a_clr = 1'b0;
  endtask

  task automatic run_b(input logic [7:0] d, input logic [7:0] c,
                       output int lat, output logic pass);
    b_mem = d; b_crc = c; b_start = 1'b1;
    tick();
    b_start = 1'b0; b_mem = ~d; b_crc = ~c;
    lat = 0;
    while (b_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    pass = b_pass;
    tick();
  endtask

  // Holds chk_start high through CALC and COMPARE, then counts any chk_done
  // in the following idle cycles.
  task automatic run_c(input logic [7:0] d, input logic c,
                       output int lat, output int extra);
    c_mem = d; c_crc = c; c_start = 1'b1;
    tick();
    c_mem = ~d; c_crc = ~c;
    lat = 0;
    while (c_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
    c_start = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (c_done === 1'b1) extra++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_busy, a_done, a_pass, a_err, a_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: got %b expected all zero", {a_busy, a_done, a_pass, a_err, a_cnt});
    end
    checks++;
    if ({b_busy, b_done, b_pass, b_err, b_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_b: got %b expected all zero", {b_busy, b_done, b_pass, b_err, b_cnt});
    end
    checks++;
    if ({c_busy, c_done, c_pass, c_err, c_cnt} !== 6'h00) begin
      errors++;
      $display("FAIL reset_c: got %b expected all zero", {c_busy, c_done, c_pass, c_err, c_cnt});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_pass_a5();
    int lat; logic p, b;
    run_a(8'hA5, 1'b0, 1'b0, lat, p, b);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL pass_latency: got %0d expected 8", lat);
    end
    checks++;
    if (p !== 1'b1) begin
      errors++; $display("FAIL pass_result: got %b expected 1", p);
    end
    checks++;
    if (b !== 1'b1) begin
      errors++; $display("FAIL busy_at_done: got %b expected 1", b);
    end
    checks++;
    if ({a_busy, a_done, a_pass, a_err, a_cnt} !== {4'b0010, 8'd0}) begin
      errors++;
      $display("FAIL pass_after: got %b expected 001000000000", {a_busy, a_done, a_pass, a_err, a_cnt});
    end
  endtask

  task automatic test_fail_clear();
    int lat; logic p, b;
    run_a(8'hA4, 1'b0, 1'b0, lat, p, b);
    checks++;
    if (p !== 1'b0) begin
      errors++; $display("FAIL fail_result: got %b expected 0", p);
    end
    checks++;
    if ({a_pass, a_err, a_cnt} !== {2'b01, 8'd1}) begin
      errors++; $display("FAIL fail_flags: got %b expected 0100000001", {a_pass, a_err, a_cnt});
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    checks++;
    if ({a_busy, a_err, a_cnt} !== {2'b00, 8'd0}) begin
      errors++; $display("FAIL err_clr: got %b expected 0000000000", {a_busy, a_err, a_cnt});
    end
  endtask

  task automatic test_crc8();
    int lat; logic p;
    run_b(8'h01, 8'h07, lat, p);
    checks++;
    if (p !== 1'b1 || lat !== 8) begin
      errors++; $display("FAIL crc8_01: got pass=%b lat=%0d expected pass=1 lat=8", p, lat);
    end
    run_b(8'hFF, 8'hF3, lat, p);
    checks++;
    if (p !== 1'b1) begin
      errors++; $display("FAIL crc8_ff_f3: got %b expected 1", p);
    end
    checks++;
    if ({b_err, b_cnt} !== 9'd0) begin
      errors++; $display("FAIL crc8_no_err: got err=%b cnt=%0d expected 0 0", b_err, b_cnt);
    end
    run_b(8'hFF, 8'hF2, lat, p);
    checks++;
    if (p !== 1'b0) begin
      errors++; $display("FAIL crc8_ff_f2: got %b expected 0", p);
    end
    checks++;
    if ({b_err, b_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL crc8_err: got err=%b cnt=%0d expected 1 1", b_err, b_cnt);
    end
  endtask

  task automatic test_saturate_busy();
    int lat, extra;
    logic [1:0] exp_cnt;
    for (int k = 1; k <= 5; k++) begin
      run_c(8'hA4, 1'b0, lat, extra);
      exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
      checks++;
      if (c_cnt !== exp_cnt) begin
        errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", k, c_cnt, exp_cnt);
      end
      checks++;
      if (extra !== 0 || lat !== 8 || c_busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_%0d: got extra=%0d lat=%0d busy=%b expected 0 8 0", k, extra, lat, c_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, dones; logic p, b;
    run_a(8'hA4, 1'b0, 1'b0, lat, p, b);
    run_a(8'hA5, 1'b0, 1'b0, lat, p, b);
    checks++;
    if ({a_pass, a_err, a_cnt} !== {2'b11, 8'd1}) begin
      errors++; $display("FAIL pre_reset: got %b expected 1100000001", {a_pass, a_err, a_cnt});
    end
    a_mem = 8'hA4; a_crc = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_done, a_pass, a_err, a_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: got %b expected all zero", {a_busy, a_done, a_pass, a_err, a_cnt});
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_done === 1'b1) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d expected 0", dones);
    end
    run_a(8'hA5, 1'b0, 1'b0, lat, p, b);
    checks++;
    if (lat !== 8 || p !== 1'b1 || a_cnt !== 8'd0) begin
      errors++; $display("FAIL post_reset: got lat=%0d pass=%b cnt=%0d expected 8 1 0", lat, p, a_cnt);
    end
  endtask

  task automatic test_clr_coincident();
    int lat; logic p, b;
    run_a(8'hA4, 1'b0, 1'b0, lat, p, b);
    run_a(8'h01, 1'b0, 1'b0, lat, p, b);
    checks++;
    if ({a_err, a_cnt} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL two_fails: got err=%b cnt=%0d expected 1 2", a_err, a_cnt);
    end
    run_a(8'hA4, 1'b0, 1'b1, lat, p, b);
    checks++;
    if ({a_err, a_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL clr_coincident: got err=%b cnt=%0d expected 1 1", a_err, a_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass_a5();
    test_fail_clear();
    test_crc8();
    test_saturate_busy();
    test_reset_mid();
    test_clr_coincident();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
